// File: rtl/ram_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ram_wb_arbiter
//
// Shares one Wishbone B3 RAM slave port between two masters (typically an
// instruction bus on m0 and a data bus on m1).
//
// Arbitration is round-robin. A grant is held for the whole Wishbone cycle,
// as long as the owner keeps cyc high, so classic and burst transfers are
// never split. Every release passes through one IDLE cycle before the next
// grant, which gives strict alternation under continuous contention.
//
// A watchdog counts consecutive strobed cycles with no slave response. When
// it expires, the owner receives a single err pulse and the slave cycle is
// dropped in that same cycle. The arbiter then waits in FLUSH until the
// offending master lowers cyc.
//
// The data path is purely combinational. Read data, write data and the
// handshakes pass straight through the owner mux with no added latency.
//
// Parameters
//   dw             data width
//   aw             address width
//   timeout_cycles stalled strobe cycles before the watchdog fires (>= 2)
//   tmo_w          watchdog counter width (2**tmo_w > timeout_cycles)
//
// Ports
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   m0_* / m1_* inputs              master requests (adr, dat, sel, we,
//                                   cyc, stb, cti, bte)
//   m0_* / m1_* outputs             master responses (dat, ack, err, rty)
//   s_*_o                           slave request, muxed from the owner
//   s_dat_i, s_ack_i, s_err_i,      slave responses
//   s_rty_i
// ---------------------------------------------------------------------------
module ram_wb_arbiter #(
    parameter int dw             = 32,
    parameter int aw             = 32,
    parameter int timeout_cycles = 16,
    parameter int tmo_w          = 5
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,

    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,

    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [tmo_w-1:0] WDOG_LAST = tmo_w'(timeout_cycles - 1);

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;        // master being flushed
    logic [tmo_w-1:0]   wdog_q, wdog_d;

    logic               sel_m1;
    logic               granted;
    logic               own_cyc;
    logic               own_stb;
    logic               slv_resp;
    logic               expire;
    logic               resp_en0;
    logic               resp_en1;

    // -----------------------------------------------------------------------
    // Owner selection. IDLE routes m0 to the slave as a harmless default.
    // In FLUSH, the mux follows the flushed master so that its cyc can be
    // observed.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_m1  = (state_q == GRANT1) || ((state_q == FLUSH) && owner_q);
        granted = (state_q == GRANT0) || (state_q == GRANT1);
    end

    assign own_cyc  = sel_m1 ? m1_cyc_i : m0_cyc_i;
    assign own_stb  = sel_m1 ? m1_stb_i : m0_stb_i;
    assign slv_resp = s_ack_i | s_err_i | s_rty_i;

    // A slave response in the expiry cycle wins, so the transfer completes
    // normally instead of erroring.
    assign expire = granted && own_cyc && own_stb && !slv_resp &&
                    (wdog_q == WDOG_LAST);

    // -----------------------------------------------------------------------
    // Slave side: combinational pass-through from the owner
    // -----------------------------------------------------------------------
    assign s_adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = sel_m1 ? m1_we_i  : m0_we_i;
    assign s_cti_o = sel_m1 ? m1_cti_i : m0_cti_i;
    assign s_bte_o = sel_m1 ? m1_bte_i : m0_bte_i;

    // cyc follows the owner combinationally, so a release is seen by the
    // slave in the same cycle. It is also cut on watchdog expiry.
    assign s_cyc_o = !wb_rst_i && granted && own_cyc && !expire;
    assign s_stb_o = !wb_rst_i && granted && own_stb && own_cyc && !expire;

    // -----------------------------------------------------------------------
    // Master side: only the owner sees responses, and none in a reset cycle
    // -----------------------------------------------------------------------
    assign resp_en0 = !wb_rst_i && (state_q == GRANT0);
    assign resp_en1 = !wb_rst_i && (state_q == GRANT1);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = resp_en0 && s_ack_i;
    assign m0_err_o = resp_en0 && (s_err_i || expire);
    assign m0_rty_o = resp_en0 && s_rty_i;

    assign m1_ack_o = resp_en1 && s_ack_i;
    assign m1_err_o = resp_en1 && (s_err_i || expire);
    assign m1_rty_o = resp_en1 && s_rty_i;

    // -----------------------------------------------------------------------
    // Next-state, round-robin and watchdog
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wdog_d       = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Contention: the master that did not win last time
                    if (last_grant_q) begin
                        state_d      = GRANT0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = GRANT1;
                        last_grant_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                end
            end

            GRANT0, GRANT1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = FLUSH;
                    owner_d = sel_m1;
                end else if (own_stb && !slv_resp) begin
                    wdog_d = wdog_q + tmo_w'(1);
                end
            end

            FLUSH: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
module tb_ram_wb_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          wb_rst_i;

    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic [3:0]    m0_sel_i, m1_sel_i;
    logic          m0_we_i, m1_we_i;
    logic          m0_cyc_i, m1_cyc_i;
    logic          m0_stb_i, m1_stb_i;
    logic [2:0]    m0_cti_i, m1_cti_i;
    logic [1:0]    m0_bte_i, m1_bte_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic          m1_ack_o, m1_err_o, m1_rty_o;

    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]    s_cti_o;
    logic [1:0]    s_bte_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i, s_rty_i;

    always #5 clk = ~clk;

    ram_wb_arbiter #(
        .dw(DW), .aw(AW), .timeout_cycles(TMO), .tmo_w(5)
    ) dut (
        .wb_clk_i(clk),       .wb_rst_i(wb_rst_i),
        .m0_adr_i(m0_adr_i),  .m0_dat_i(m0_dat_i),  .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i),    .m0_cyc_i(m0_cyc_i),  .m0_stb_i(m0_stb_i),
        .m0_cti_i(m0_cti_i),  .m0_bte_i(m0_bte_i),  .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o),  .m0_err_o(m0_err_o),  .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i),  .m1_dat_i(m1_dat_i),  .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i),    .m1_cyc_i(m1_cyc_i),  .m1_stb_i(m1_stb_i),
        .m1_cti_i(m1_cti_i),  .m1_bte_i(m1_bte_i),  .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o),  .m1_err_o(m1_err_o),  .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o),    .s_dat_o(s_dat_o),    .s_sel_o(s_sel_o),
        .s_we_o(s_we_o),      .s_cyc_o(s_cyc_o),    .s_stb_o(s_stb_o),
        .s_cti_o(s_cti_o),    .s_bte_o(s_bte_o),    .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),    .s_err_i(s_err_i),    .s_rty_i(s_rty_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: who owns the RAM, whether we are flushing, who won
    // last, and how many stalled strobes in a row the owner has seen.
    // -----------------------------------------------------------------------
    int mo_owner = -1;   // -1 = nobody
    bit mo_flush = 1'b0;
    int mo_last  = 1;
    int mo_stall = 0;
    bit mo_valid = 1'b0;

    always @(negedge clk) begin : model_check
        bit owned, use1, oc, os, resp, expire;
        owned  = mo_valid && (mo_owner >= 0) && !mo_flush;
        use1   = (mo_owner == 1);
        oc     = use1 ? m1_cyc_i : m0_cyc_i;
        os     = use1 ? m1_stb_i : m0_stb_i;
        resp   = s_ack_i || s_err_i || s_rty_i;
        expire = owned && oc && os && !resp && (mo_stall == TMO - 1);

        if (mo_valid) begin
            if (!wb_rst_i) begin
                chk("s_cyc_o", 32'(s_cyc_o), 32'(owned && oc && !expire));
                chk("s_stb_o", 32'(s_stb_o), 32'(owned && oc && os && !expire));
            end
            if (!mo_flush) begin
                chk("s_adr_o", s_adr_o, use1 ? m1_adr_i : m0_adr_i);
                chk("s_dat_o", s_dat_o, use1 ? m1_dat_i : m0_dat_i);
                chk("s_ctl_o", {21'd0, s_sel_o, s_we_o, s_cti_o, s_bte_o},
                    use1 ? {21'd0, m1_sel_i, m1_we_i, m1_cti_i, m1_bte_i}
                         : {21'd0, m0_sel_i, m0_we_i, m0_cti_i, m0_bte_i});
            end
            chk("m0_ack_o", 32'(m0_ack_o), 32'(!wb_rst_i && owned && mo_owner == 0 && s_ack_i));
            chk("m0_err_o", 32'(m0_err_o), 32'(!wb_rst_i && owned && mo_owner == 0 && (s_err_i || expire)));
            chk("m0_rty_o", 32'(m0_rty_o), 32'(!wb_rst_i && owned && mo_owner == 0 && s_rty_i));
            chk("m1_ack_o", 32'(m1_ack_o), 32'(!wb_rst_i && owned && mo_owner == 1 && s_ack_i));
            chk("m1_err_o", 32'(m1_err_o), 32'(!wb_rst_i && owned && mo_owner == 1 && (s_err_i || expire)));
            chk("m1_rty_o", 32'(m1_rty_o), 32'(!wb_rst_i && owned && mo_owner == 1 && s_rty_i));
            chk("m0_dat_o", m0_dat_o, s_dat_i);
            chk("m1_dat_o", m1_dat_o, s_dat_i);
        end

        // what the coming clock edge does
        if (wb_rst_i) begin
            mo_owner = -1; mo_flush = 1'b0; mo_last = 1; mo_stall = 0; mo_valid = 1'b1;
        end else if (mo_valid) begin
            if (mo_owner < 0) begin
                if (m0_cyc_i && m1_cyc_i) mo_owner = 1 - mo_last;
                else if (m0_cyc_i)        mo_owner = 0;
                else if (m1_cyc_i)        mo_owner = 1;
                if (mo_owner >= 0) mo_last = mo_owner;
                mo_stall = 0;
            end else if (mo_flush) begin
                if (!oc) begin mo_owner = -1; mo_flush = 1'b0; end
            end else begin
                if (!oc) begin
                    mo_owner = -1; mo_stall = 0;
                end else if (expire) begin
                    mo_flush = 1'b1; mo_stall = 0;
                end else if (os && !resp) begin
                    mo_stall = mo_stall + 1;
                end else begin
                    mo_stall = 0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        m0_cti_i = 3'b000; m1_cti_i = 3'b000; m0_bte_i = 2'b00; m1_bte_i = 2'b00;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        wb_rst_i = 1'b1;
        idle_masters();
        tick();
        wb_rst_i = 1'b0;
    endtask

    int g;
    int err_cycle;
    int ph;

    initial begin
        wb_rst_i = 1'b1;
        m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
        m0_sel_i = 4'hF; m1_sel_i = 4'hF; m0_we_i = 1'b0; m1_we_i = 1'b0;
        s_dat_i = '0;
        idle_masters();
        tick(); tick();
        wb_rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_acks", {26'd0, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 32'd0);

        // m0 classic read, m1 idle
        do_reset();
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
        @(negedge clk); chk("rd_c0_s_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("rd_c1_s_cyc", 32'(s_cyc_o), 32'd1);
        chk("rd_c1_s_adr", s_adr_o, 32'h0000_0100);
        tick(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        @(negedge clk); chk("rd_c2_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("rd_c2_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_c2_m1_ack", 32'(m1_ack_o), 32'd0);
        tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk); chk("rd_c3_s_cyc", 32'(s_cyc_o), 32'd0);

        // Both request together after reset: m0 first, then IDLE, then m1
        do_reset();
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h10;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h20;
        tick(); s_ack_i = 1'b1;
        @(negedge clk); chk("both_first_adr", s_adr_o, 32'h10);
        chk("both_first_m0ack", 32'(m0_ack_o), 32'd1);
        chk("both_first_m1ack", 32'(m1_ack_o), 32'd0);
        tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk); chk("both_release_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("both_idle_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("both_m1_cyc", 32'(s_cyc_o), 32'd1);
        chk("both_m1_adr", s_adr_o, 32'h20);

        // Burst lock: 4-beat incrementing burst on m0, m1 requests at beat 2
        do_reset();
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h200; m0_cti_i = 3'b010;
        m1_adr_i = 32'h300;
        for (int b = 0; b < 4; b++) begin
            tick();
            m0_adr_i = 32'h200 + 32'(4 * b);
            m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
            s_ack_i  = 1'b1;
            if (b == 1) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
            @(negedge clk);
            chk("burst_adr", s_adr_o, 32'h200 + 32'(4 * b));
            chk("burst_m0ack", 32'(m0_ack_o), 32'd1);
            chk("burst_m1ack", 32'(m1_ack_o), 32'd0);
        end
        chk("burst_last_cti", 32'(s_cti_o), 32'd7);
        tick(); m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk); chk("burst_drop_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("burst_idle_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("burst_m1_cyc", 32'(s_cyc_o), 32'd1);
        chk("burst_m1_adr", s_adr_o, 32'h300);

        // Fairness: both request continuously
        do_reset();
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tick(); s_ack_i = 1'b1;
            @(negedge clk);
            g = m0_ack_o ? 0 : (m1_ack_o ? 1 : 2);
            chk("fair_grant", 32'(g), 32'(r % 2));
            tick(); s_ack_i = 1'b0;
            if (g == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            if (g == 1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        end

        // Watchdog on m1
        do_reset();
        tick(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m0_adr_i = 32'hA0;
        err_cycle = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            @(negedge clk);
            if (m1_err_o) begin
                err_cycle = k;
                chk("wdog_cut_cyc", 32'(s_cyc_o), 32'd0);
                chk("wdog_cut_stb", 32'(s_stb_o), 32'd0);
                break;
            end
        end
        chk("wdog_err_cycle", 32'(err_cycle), 32'd16);
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
        @(negedge clk); chk("flush_err_once", 32'(m1_err_o), 32'd0);
        chk("flush_cyc", 32'(s_cyc_o), 32'd0);
        chk("flush_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        tick();
        @(negedge clk); chk("flush_hold_cyc", 32'(s_cyc_o), 32'd0);
        tick(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk); chk("flush_rel_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("flush_idle_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk); chk("flush_m0_cyc", 32'(s_cyc_o), 32'd1);
        chk("flush_m0_adr", s_adr_o, 32'hA0);

        // Reset in the middle of an m1 burst
        do_reset();
        tick(); m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; m1_adr_i = 32'h400;
        m0_adr_i = 32'h500;
        tick(); s_ack_i = 1'b1;
        @(negedge clk); chk("mrst_beat_ack", 32'(m1_ack_o), 32'd1);
        tick(); wb_rst_i = 1'b1; m1_adr_i = 32'h404;
        @(negedge clk); chk("mrst_rst_cycle_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        tick(); wb_rst_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        @(negedge clk); chk("mrst_after_cyc", 32'(s_cyc_o), 32'd0);
        chk("mrst_after_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        tick(); s_ack_i = 1'b0;
        @(negedge clk); chk("mrst_m0_wins_cyc", 32'(s_cyc_o), 32'd1);
        chk("mrst_m0_wins_adr", s_adr_o, 32'h500);

        // Randomised traffic, checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 4500; i++) begin
            tick();
            ph = (i / 250) % 3;
            wb_rst_i = ($urandom_range(0, 699) == 0);
            if (m0_cyc_i) begin
                if ($urandom_range(0, (ph == 0) ? 39 : 15) == 0) m0_cyc_i = 1'b0;
            end else if ($urandom_range(0, 3) == 0) m0_cyc_i = 1'b1;
            if (m1_cyc_i) begin
                if ($urandom_range(0, (ph == 0) ? 39 : 15) == 0) m1_cyc_i = 1'b0;
            end else if ($urandom_range(0, 3) == 0) m1_cyc_i = 1'b1;
            m0_stb_i = m0_cyc_i && ((ph == 0) || ($urandom_range(0, 3) != 0));
            m1_stb_i = m1_cyc_i && ((ph == 0) || ($urandom_range(0, 3) != 0));
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            m0_sel_i = 4'($urandom_range(0, 15)); m1_sel_i = 4'($urandom_range(0, 15));
            m0_we_i  = 1'($urandom_range(0, 1));  m1_we_i  = 1'($urandom_range(0, 1));
            m0_cti_i = 3'($urandom_range(0, 7));  m1_cti_i = 3'($urandom_range(0, 7));
            m0_bte_i = 2'($urandom_range(0, 3));  m1_bte_i = 2'($urandom_range(0, 3));
            s_dat_i  = $urandom;
            case (ph)
                0: begin s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; end
                1: begin
                    s_ack_i = ($urandom_range(0, 7) == 0);
                    s_err_i = 1'b0; s_rty_i = 1'b0;
                end
                default: begin
                    s_ack_i = ($urandom_range(0, 1) == 0);
                    s_err_i = ($urandom_range(0, 15) == 0);
                    s_rty_i = ($urandom_range(0, 15) == 0);
                end
            endcase
        end
        tick();
        wb_rst_i = 1'b0;
        idle_masters();
        tick();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
